// File: rtl/riscv_irq_dispatcher.sv
// rtl/riscv_irq_dispatcher.sv - edge-collecting interrupt dispatcher driving the core irq request interface
// Highest pending+enabled ID wins; one request is held until acked, then a one-cycle gap.
module riscv_irq_dispatcher #(
  parameter int NUM_IRQ = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic [NUM_IRQ-1:0] irq_sec_mask_i,
  input  logic [NUM_IRQ-1:0] sw_set_i,
  input  logic [NUM_IRQ-1:0] sw_clr_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  output logic               irq_sec_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i,
  output logic [NUM_IRQ-1:0] pending_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_line;
  logic               r_irq;
  logic [4:0]         r_id;
  logic               r_sec;

  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_ack_clr;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_pending_next;
  logic [31:0]        w_live_ext;
  logic [31:0]        w_sec_ext;
  logic [4:0]         w_arb_id;

  assign w_edge = irq_lines_i & ~r_line;
  assign w_cand = r_pending & irq_mask_i;

  // IDs at or above NUM_IRQ never match a line, so such acks clear nothing.
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_ack_clr[i] = irq_ack_i && (irq_ack_id_i == 5'(i));
    end
  end

  // Set sources win over clears hitting the same bit in the same cycle.
  assign w_pending_next = (r_pending & ~(sw_clr_i | w_ack_clr)) | w_edge | sw_set_i;

  always_comb begin
    w_arb_id = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_cand[i]) w_arb_id = 5'(i);
    end
  end

  assign w_live_ext = 32'(w_cand);
  assign w_sec_ext  = 32'(irq_sec_mask_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_line    <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_line    <= irq_lines_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_id    <= '0;
      r_sec   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_cand) begin
            r_id    <= w_arb_id;
            r_sec   <= w_sec_ext[w_arb_id];
            r_irq   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // Any ack ends the request, even one naming a different ID.
          if (irq_ack_i) begin
            r_irq   <= 1'b0;
            r_state <= S_GAP;
          end else if (!w_live_ext[r_id]) begin
            r_irq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign irq_o     = r_irq;
  assign irq_id_o  = r_id;
  assign irq_sec_o = r_sec;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_riscv_irq_dispatcher.sv
// tb/tb_riscv_irq_dispatcher.sv - randomized and directed checks of riscv_irq_dispatcher against a behavioural model
module tb_riscv_irq_dispatcher;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] lines = '0, mask = '0, secm = '0, sset = '0, sclr = '0;
  logic         ack = 1'b0;
  logic [4:0]   ack_id = '0;
  logic         irq;
  logic [4:0]   irq_id;
  logic         irq_sec;
  logic [N-1:0] pend;

  int total = 0;
  int bad = 0;

  riscv_irq_dispatcher #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .irq_lines_i(lines), .irq_mask_i(mask), .irq_sec_mask_i(secm),
    .sw_set_i(sset), .sw_clr_i(sclr),
    .irq_o(irq), .irq_id_o(irq_id), .irq_sec_o(irq_sec),
    .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .pending_o(pend)
  );

  always #5 clk = ~clk;

  // Model: pending set, previous line values, and the request phase
  // (0 = nothing requested, 1 = request held, 2 = post-ack gap).
  bit [N-1:0] m_pend, m_line;
  int         m_phase, m_id;
  bit         m_irq, m_sec;

  function automatic int highest(input bit [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_line = '0; m_phase = 0; m_id = 0; m_irq = 0; m_sec = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] rises, acked, cand;
    int top;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rises = lines & ~m_line;
    acked = '0;
    if (ack && int'(ack_id) < N) acked[ack_id] = 1'b1;
    cand = m_pend & mask;
    if (m_phase == 0) begin
      top = highest(cand);
      if (top >= 0) begin
        m_id = top; m_sec = secm[top]; m_irq = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        m_irq = 0; m_phase = 2;
      end else if (!(m_pend[m_id] && mask[m_id])) begin
        m_irq = 0; m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~(sclr | acked)) | rises | sset;
    m_line = lines;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("irq_o", 32'(irq), 32'(m_irq));
    chk("irq_id_o", 32'(irq_id), 32'(m_id));
    chk("irq_sec_o", 32'(irq_sec), 32'(m_sec));
    chk("pending_o", 32'(pend), 32'(m_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic pulses_off();
    sset = '0; sclr = '0; ack = 1'b0; ack_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lines = '0; mask = '1; secm = '0; pulses_off();
    #1;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    tick();
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    do_reset();

    // Line 5 rise: pending next cycle, request the cycle after; ack clears.
    lines[5] = 1'b1; tick();
    chk("t1_pend5", 32'(pend[5]), 32'd1);
    chk("t1_irq_early", 32'(irq), 32'd0);
    tick();
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_id", 32'(irq_id), 32'd5);
    ack = 1'b1; ack_id = 5'd5; tick(); pulses_off();
    chk("t1_irq_off", 32'(irq), 32'd0);
    chk("t1_pend5_clr", 32'(pend[5]), 32'd0);

    // Lines 3 and 20 together: 20 first, 3 after the gap.
    do_reset();
    lines[3] = 1'b1; lines[20] = 1'b1; tick(); tick();
    chk("t2_id20", 32'(irq_id), 32'd20);
    ack = 1'b1; ack_id = 5'd20; tick(); pulses_off();
    chk("t2_gap", 32'(irq), 32'd0);
    tick();
    chk("t2_idle", 32'(irq), 32'd0);
    tick();
    chk("t2_irq3", 32'(irq), 32'd1);
    chk("t2_id3", 32'(irq_id), 32'd3);

    // Software clear withdraws a held request without ack.
    do_reset();
    sset[7] = 1'b1; tick(); pulses_off(); tick();
    chk("t3_id7", 32'(irq_id), 32'd7);
    sclr[7] = 1'b1; tick(); pulses_off(); tick();
    chk("t3_withdrawn", 32'(irq), 32'd0);
    tick();
    chk("t3_stays_idle", 32'(irq), 32'd0);

    // Ack and a fresh rise on the same bit: pending survives, re-requested.
    do_reset();
    sset[7] = 1'b1; tick(); pulses_off(); tick();
    ack = 1'b1; ack_id = 5'd7; lines[7] = 1'b1; tick(); pulses_off();
    chk("t4_pend7", 32'(pend[7]), 32'd1);
    tick(); tick();
    chk("t4_rereq", 32'(irq), 32'd1);
    chk("t4_id7", 32'(irq_id), 32'd7);

    // Masked pending stays silent until the mask bit opens.
    do_reset();
    mask[9] = 1'b0; secm[9] = 1'b1;
    sset[9] = 1'b1; tick(); pulses_off(); tick(); tick();
    chk("t5_masked", 32'(irq), 32'd0);
    mask[9] = 1'b1; tick();
    chk("t5_irq", 32'(irq), 32'd1);
    chk("t5_id9", 32'(irq_id), 32'd9);
    chk("t5_sec", 32'(irq_sec), 32'd1);

    // Asynchronous reset mid-request; held line re-requests two cycles after release.
    do_reset();
    lines[12] = 1'b1; tick(); tick();
    chk("t6_irq_up", 32'(irq), 32'd1);
    rst_n = 1'b0; #1;
    model_reset();
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_id", 32'(irq_id), 32'd0);
    chk("t6_rst_pend", 32'(pend), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_not_yet", 32'(irq), 32'd0);
    tick();
    chk("t6_reassert", 32'(irq), 32'd1);
    chk("t6_id12", 32'(irq_id), 32'd12);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      lines = lines ^ (N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) mask = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 31) == 0) secm = N'($urandom);
      sset = ($urandom_range(0, 3) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      sclr = ($urandom_range(0, 5) == 0) ? (N'($urandom) & N'($urandom) & N'($urandom)) : '0;
      ack = 1'b0;
      if (m_phase == 1 && $urandom_range(0, 3) == 0) begin
        ack = 1'b1;
        ack_id = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(m_id);
      end else if ($urandom_range(0, 40) == 0) begin
        ack = 1'b1;
        ack_id = 5'($urandom);
      end
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
